adc_capture_core: RTL and testbench

ADC_CAPTURE_CORE -- requirements
Module: adc_capture_core

---
 rtl/adc_capture_core.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_adc_capture_core.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_core.sv
// rtl/adc_capture_core.sv - ADC serial configuration sequencer and sample capture/averaging core
//
// Purpose:
//   After reset, or after a cfg_start pulse, this block pulses the ADC hardware
//   reset, waits, and then shifts CFG_WORDS 16-bit words out over a 3-wire
//   serial port.  Each word is sent MSB first and is followed by a gap.  Once
//   configuration is complete, raw ADC samples are registered and converted to
//   two's complement when requested.  Blocks of 2^avg_log2 samples are then
//   averaged.
//
// Optional feature:
//   ADC_CAPTURE_OVR_EN - when defined, out_ovr flags any block that contained a
//   raw sample at either rail (all zeros or all ones).  When undefined, out_ovr
//   is tied to 0.
//
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   cfg_start        - single-cycle pulse that restarts configuration
//   cfg_table        - CFG_WORDS x {addr[7:0], data[7:0]}; word k at [16k+15:16k]
//   adc_rst          - ADC hardware reset
//   adc_sen          - serial enable, active-low
//   adc_sclk         - serial clock
//   adc_sdata        - serial data
//   cfg_done         - high while configuration is complete
//   adc_data         - raw offset-binary samples
//   fmt_twos         - 1: two's complement output, 0: offset binary output
//   avg_log2         - log2 of the averaging block size (values above 4 clamp to 4)
//   out_data         - averaged output sample
//   out_valid        - output sample strobe
//   out_ovr          - rail flag for the block just output
module adc_capture_core #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned CFG_WORDS  = 4,
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_start,
    input  logic [16*CFG_WORDS-1:0] cfg_table,
    output logic                    adc_rst,
    output logic                    adc_sen,
    output logic                    adc_sclk,
    output logic                    adc_sdata,
    output logic                    cfg_done,
    input  logic [DATA_W-1:0]       adc_data,
    input  logic                    fmt_twos,
    input  logic [2:0]              avg_log2,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    output logic                    out_ovr
);

    localparam int unsigned ACC_W = DATA_W + 4;
    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCLK_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [3:0]       WORD_LAST = 4'(CFG_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_PULSE,
        S_RST_WAIT,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    // ---------------------------------------------------------------- config FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [3:0]       word_q, word_d;
    logic             sclk_q, sclk_d;
    logic             sdata_q, sdata_d;
    logic [3:0]       word_nxt;
    logic [15:0]      cur_word;
    logic [15:0]      nxt_word;

    assign word_nxt = word_q + 4'd1;
    assign cur_word = cfg_table[{word_q, 4'b0000} +: 16];
    assign nxt_word = cfg_table[{word_nxt, 4'b0000} +: 16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        word_d  = word_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RST_PULSE;
                cnt_d   = '0;
                word_d  = '0;
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
            end
            S_RST_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    // sdata takes the first MSB together with the sen falling edge
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    sclk_d  = 1'b0;
                    sdata_d = cur_word[15];
                end
            end
            S_SHIFT: begin
                if (cnt_q == SCLK_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // falling edge: the only point where sdata may move
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = S_GAP;
                            sdata_d = 1'b0;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            sdata_d = cur_word[bit_q - 4'd1];
                        end
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        word_d  = word_nxt;
                        bit_d   = 4'd15;
                        sdata_d = nxt_word[15];
                    end
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (cfg_start) begin
            state_d = S_RST_PULSE;
            cnt_d   = '0;
            word_d  = '0;
            bit_d   = 4'd15;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
        end
    end

    assign adc_rst   = (state_q == S_RST_PULSE);
    assign adc_sen   = (state_q != S_SHIFT);
    assign adc_sclk  = sclk_q;
    assign adc_sdata = sdata_q;
    assign cfg_done  = (state_q == S_DONE);

    // ---------------------------------------------------------------- capture
    logic [DATA_W-1:0] s1_q, s1_d;
    logic              v1_q, v1_d;
    logic [DATA_W-1:0] s2_q, s2_d;
    logic              s2_twos_q, s2_twos_d;
    logic              v2_q, v2_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [3:0]        blk_cnt_q, blk_cnt_d;
    logic [2:0]        shift_q, shift_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        avg_eff;
    logic [2:0]        shift_now;
    logic [ACC_W-1:0]  ext;
    logic [ACC_W-1:0]  sum;
    logic              blk_last;

    always_comb begin
        s1_d        = adc_data;
        v1_d        = cfg_done;
        s2_d        = fmt_twos ? {~s1_q[DATA_W-1], s1_q[DATA_W-2:0]} : s1_q;
        s2_twos_d   = fmt_twos;
        v2_d        = v1_q;
        acc_d       = acc_q;
        blk_cnt_d   = blk_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        avg_eff   = (avg_log2 > 3'd4) ? 3'd4 : avg_log2;
        // block size is latched on its first sample so mid-block changes are ignored
        shift_now = (blk_cnt_q == 4'd0) ? avg_eff : shift_q;
        ext       = s2_twos_q ? {{4{s2_q[DATA_W-1]}}, s2_q} : {4'b0000, s2_q};
        sum       = acc_q + ext;
        blk_last  = (blk_cnt_q == 4'((5'd1 << shift_now) - 5'd1));

        if (v2_q) begin
            shift_d = shift_now;
            if (blk_last) begin
                // shift <= 4 keeps the window inside the accumulator, so the
                // same slice serves as a logical or an arithmetic shift
                out_data_d  = sum[shift_now +: DATA_W];
                out_valid_d = 1'b1;
                acc_d       = '0;
                blk_cnt_d   = '0;
            end else begin
                acc_d     = sum;
                blk_cnt_d = blk_cnt_q + 4'd1;
            end
        end

        if (cfg_start) begin
            s1_d        = '0;
            v1_d        = 1'b0;
            s2_d        = '0;
            v2_d        = 1'b0;
            acc_d       = '0;
            blk_cnt_d   = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            s2_q        <= '0;
            s2_twos_q   <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            blk_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            v1_q        <= v1_d;
            s2_q        <= s2_d;
            s2_twos_q   <= s2_twos_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            blk_cnt_q   <= blk_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef ADC_CAPTURE_OVR_EN
    // ---------------------------------------------------------------- rail flag
    logic s2_ovr_q, s2_ovr_d;
    logic ovr_acc_q, ovr_acc_d;
    logic out_ovr_q, out_ovr_d;
    logic blk_ovr;

    always_comb begin
        s2_ovr_d  = (s1_q == '0) || (s1_q == '1);
        ovr_acc_d = ovr_acc_q;
        out_ovr_d = out_ovr_q;
        blk_ovr   = ovr_acc_q | s2_ovr_q;
        if (v2_q) begin
            if (blk_last) begin
                out_ovr_d = blk_ovr;
                ovr_acc_d = 1'b0;
            end else begin
                ovr_acc_d = blk_ovr;
            end
        end
        if (cfg_start) begin
            s2_ovr_d  = 1'b0;
            ovr_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_ovr_q  <= 1'b0;
            ovr_acc_q <= 1'b0;
            out_ovr_q <= 1'b0;
        end else begin
            s2_ovr_q  <= s2_ovr_d;
            ovr_acc_q <= ovr_acc_d;
            out_ovr_q <= out_ovr_d;
        end
    end

    assign out_ovr = out_ovr_q;
`else
    assign out_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_adc_capture_core.sv
// tb/tb_adc_capture_core.sv - directed self-checking bench for adc_capture_core
module tb_adc_capture_core;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_table = {16'h4280, 16'h0001};
    logic        adc_rst, adc_sen, adc_sclk, adc_sdata, cfg_done;
    logic [11:0] adc_data = 12'h000;
    logic        fmt_twos = 1'b0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [11:0] out_data;
    logic        out_valid, out_ovr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] samp  [32];
    int          n_samp;
    logic [11:0] fill;
    logic        obs_v [32];
    logic [11:0] obs_d [32];
    logic        obs_o [32];
    logic        exp_ovr;
    int          nv;

    adc_capture_core #(
        .DATA_W    (12),
        .CFG_WORDS (2),
        .SCLK_DIV  (4),
        .RST_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_start (cfg_start),
        .cfg_table (cfg_table),
        .adc_rst   (adc_rst),
        .adc_sen   (adc_sen),
        .adc_sclk  (adc_sclk),
        .adc_sdata (adc_sdata),
        .cfg_done  (cfg_done),
        .adc_data  (adc_data),
        .fmt_twos  (fmt_twos),
        .avg_log2  (avg_log2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ovr   (out_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Follows one full configuration sequence up to cfg_done, measuring the
    // serial waveform; optionally starts it with a cfg_start pulse.
    task automatic run_cfg(input bit pulse);
        int rst_hi = 0, wait_cnt = 0, rises = 0, sen_lo = 0, bad_sd = 0, nval = 0, done_cyc = 0;
        logic [31:0] cap = '0;
        logic p_sclk, p_sen, p_sd;
        p_sclk = adc_sclk;
        p_sen  = adc_sen;
        p_sd   = adc_sdata;
        if (pulse) cfg_start = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            cfg_start = 1'b0;
            if (cyc == 1) begin
                check("cfg_first_adc_rst", 32'(adc_rst), 32'd1);
                check("cfg_first_done", 32'(cfg_done), 32'd0);
                check("cfg_first_sen", 32'(adc_sen), 32'd1);
            end
            if (adc_rst) rst_hi++;
            if (rst_hi > 0 && !adc_rst && adc_sen && rises == 0) wait_cnt++;
            if (!adc_sen) sen_lo++;
            if (adc_sclk && !p_sclk) begin
                rises++;
                cap = {cap[30:0], adc_sdata};
            end
            if (cyc > 1 && adc_sdata != p_sd && !(p_sclk && !adc_sclk) && !(p_sen && !adc_sen))
                bad_sd++;
            if (out_valid) nval++;
            if (cfg_done) begin
                done_cyc = cyc;
                break;
            end
            p_sclk = adc_sclk;
            p_sen  = adc_sen;
            p_sd   = adc_sdata;
        end
        check("cfg_rst_high_cycles", 32'(rst_hi), 32'd16);
        check("cfg_rst_wait_cycles", 32'(wait_cnt), 32'd16);
        check("cfg_sclk_rises", 32'(rises), 32'd32);
        check("cfg_shifted_bits", cap, 32'h0001_4280);
        check("cfg_sen_low_cycles", 32'(sen_lo), 32'd256);
        check("cfg_sdata_edges", 32'(bad_sd), 32'd0);
        check("cfg_no_valid", 32'(nval), 32'd0);
        check("cfg_done_cycle", 32'(done_cyc), 32'd305);
    endtask

    // Drives samp[0..n_samp-1] then fill, one per cycle starting at the current
    // negedge, and records the outputs seen before each drive.
    task automatic capture(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            obs_v[c] = out_valid;
            obs_d[c] = out_data;
            obs_o[c] = out_ovr;
            adc_data = (c < n_samp) ? samp[c] : fill;
            @(negedge clk);
        end
    endtask

    initial begin
`ifdef ADC_CAPTURE_OVR_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        // reset state
        fmt_twos = 1'b1;
        avg_log2 = 3'd0;
        repeat (2) @(negedge clk);
        check("rst_adc_rst", 32'(adc_rst), 32'd0);
        check("rst_adc_sen", 32'(adc_sen), 32'd1);
        check("rst_adc_sclk", 32'(adc_sclk), 32'd0);
        check("rst_adc_sdata", 32'(adc_sdata), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ovr", 32'(out_ovr), 32'd0);
        rstn = 1'b1;
        run_cfg(1'b0);

        // two's complement conversion, no averaging, 3-cycle latency
        samp[0] = 12'h800; samp[1] = 12'hFFF; n_samp = 2; fill = 12'h800;
        capture(8);
        check("twos_lat_early", 32'(obs_v[2]), 32'd0);
        check("twos_v0", 32'(obs_v[3]), 32'd1);
        check("twos_d0", 32'(obs_d[3]), 32'h000);
        check("twos_v1", 32'(obs_v[4]), 32'd1);
        check("twos_d1", 32'(obs_d[4]), 32'h7FF);
        check("twos_v2", 32'(obs_v[5]), 32'd1);
        check("twos_d2", 32'(obs_d[5]), 32'h000);

        // offset binary, block of 4
        fmt_twos = 1'b0; avg_log2 = 3'd2;
        run_cfg(1'b1);
        samp[0] = 12'd100; samp[1] = 12'd101; samp[2] = 12'd102; samp[3] = 12'd104;
        n_samp = 4; fill = 12'h000;
        capture(10);
        nv = 0;
        for (int i = 0; i < 10; i++) nv += int'(obs_v[i]);
        check("avg4_valid_count", 32'(nv), 32'd1);
        check("avg4_valid", 32'(obs_v[6]), 32'd1);
        check("avg4_data", 32'(obs_d[6]), 32'd101);
        check("avg4_hold_valid", 32'(obs_v[8]), 32'd0);
        check("avg4_hold_data", 32'(obs_d[8]), 32'd101);

        // avg_log2 above 4 clamps to 16-sample blocks
        avg_log2 = 3'd7;
        run_cfg(1'b1);
        for (int i = 0; i < 16; i++) samp[i] = 12'(200 + i);
        n_samp = 16; fill = 12'h000;
        capture(20);
        nv = 0;
        for (int i = 0; i < 20; i++) nv += int'(obs_v[i]);
        check("clamp_valid_count", 32'(nv), 32'd1);
        check("clamp_valid", 32'(obs_v[18]), 32'd1);
        check("clamp_data", 32'(obs_d[18]), 32'd207);

        // negative two's complement average rounds toward minus infinity
        fmt_twos = 1'b1; avg_log2 = 3'd1;
        run_cfg(1'b1);
        samp[0] = 12'h000; samp[1] = 12'h001; n_samp = 2; fill = 12'h800;
        capture(6);
        check("neg_valid", 32'(obs_v[4]), 32'd1);
        check("neg_data", 32'(obs_d[4]), 32'h800);
        check("neg_ovr", 32'(obs_o[4]), 32'(exp_ovr));

        // cfg_start from DONE, then again mid-SHIFT of word 1
        fmt_twos = 1'b0; avg_log2 = 3'd1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("restart_done_low", 32'(cfg_done), 32'd0);
        check("restart_adc_rst", 32'(adc_rst), 32'd1);
        nv = 0;
        for (int i = 0; i < 199; i++) begin
            @(negedge clk);
            nv += int'(out_valid);
        end
        check("midshift_sen_low", 32'(adc_sen), 32'd0);
        check("midshift_no_valid", 32'(nv), 32'd0);
        run_cfg(1'b1);

        // rail flag per block
        samp[0] = 12'hFFF; samp[1] = 12'h123; samp[2] = 12'h010; samp[3] = 12'h020;
        n_samp = 4; fill = 12'h400;
        capture(8);
        check("ovr_blk1_valid", 32'(obs_v[4]), 32'd1);
        check("ovr_blk1_data", 32'(obs_d[4]), 32'h891);
        check("ovr_blk1_flag", 32'(obs_o[4]), 32'(exp_ovr));
        check("ovr_blk1_hold", 32'(obs_o[5]), 32'(exp_ovr));
        check("ovr_blk2_valid", 32'(obs_v[6]), 32'd1);
        check("ovr_blk2_data", 32'(obs_d[6]), 32'h018);
        check("ovr_blk2_flag", 32'(obs_o[6]), 32'd0);

        // one-cycle reset in the middle of averaging
        avg_log2 = 3'd2;
        n_samp = 0; fill = 12'h050;
        capture(6);
        rstn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_cfg_done", 32'(cfg_done), 32'd0);
        check("midrst_adc_rst", 32'(adc_rst), 32'd0);
        check("midrst_adc_sen", 32'(adc_sen), 32'd1);
        check("midrst_out_ovr", 32'(out_ovr), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_cfg(1'b0);
        samp[0] = 12'd8; samp[1] = 12'd8; samp[2] = 12'd8; samp[3] = 12'd12;
        n_samp = 4; fill = 12'h100;
        capture(8);
        check("postrst_valid", 32'(obs_v[6]), 32'd1);
        check("postrst_data", 32'(obs_d[6]), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
